// File: rtl/hdu_scoreboard_pkg.sv
// rtl/hdu_scoreboard_pkg.sv - shared defaults and types for the hazard detection unit
package hdu_scoreboard_pkg;

  localparam int RF_ADDR_WIDTH_DEFAULT   = 5;
  localparam int MAX_OUTSTANDING_DEFAULT = 4;

  // Individual hazard causes evaluated for the instruction sitting in ID
  typedef struct packed {
    logic raw;
    logic waw;
    logic str;
  } hazard_t;

endpackage

// File: rtl/hdu_busy_table.sv
// rtl/hdu_busy_table.sv - per-register busy bits for in-flight long-latency results
module hdu_busy_table #(
  parameter int ADDR_WIDTH = 5,
  localparam int NUM_REGS = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  setEn,
  input  logic [ADDR_WIDTH-1:0] setIdx,
  input  logic                  clrEn,
  input  logic [ADDR_WIDTH-1:0] clrIdx,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  // Decode set/clear requests into one-hot masks
  always_comb begin
    setMask = setEn ? (NUM_REGS'(1) << setIdx) : '0;
    clrMask = clrEn ? (NUM_REGS'(1) << clrIdx) : '0;
  end

  // Clear first, then set, so a coincident set wins; x0 can never be busy
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~clrMask) | setMask) & ~NUM_REGS'(1);
    end
  end

endmodule

// File: rtl/hdu_scoreboard.sv
// rtl/hdu_scoreboard.sv - scoreboard hazard detection unit beside the ID stage
module hdu_scoreboard
  import hdu_scoreboard_pkg::*;
#(
  parameter int RF_ADDR_WIDTH   = RF_ADDR_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1),
  localparam int NUM_REGS  = 2 ** RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idValid,
  input  logic [RF_ADDR_WIDTH-1:0] idRs1,
  input  logic [RF_ADDR_WIDTH-1:0] idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic [RF_ADDR_WIDTH-1:0] idRd,
  input  logic                     idRegWrite,
  input  logic                     idLongLat,
  input  logic                     branchOrJump,
  input  logic                     wbValid,
  input  logic [RF_ADDR_WIDTH-1:0] wbRd,
  output logic                     stall,
  output logic                     flush,
  output logic                     issue,
  output logic [NUM_REGS-1:0]      busyVec,
  output logic [CNT_WIDTH-1:0]     outstanding,
  output logic                     protoErr
);

  logic [NUM_REGS-1:0] wbMask;
  logic [NUM_REGS-1:0] busyEff;
  hazard_t             haz;
  logic                incr;
  logic                decr;
  logic                setEn;
  logic                clrEn;

  // Hazard equations; the register completing this cycle is treated as ready
  always_comb begin
    wbMask  = wbValid ? (NUM_REGS'(1) << wbRd) : '0;
    busyEff = busyVec & ~wbMask;
    haz.raw = (idUsesRs1 && (idRs1 != '0) && busyEff[idRs1]) ||
              (idUsesRs2 && (idRs2 != '0) && busyEff[idRs2]);
    haz.waw = idRegWrite && (idRd != '0) && busyEff[idRd];
    // Deliberately ignores a same-cycle retire to keep the path short
    haz.str = idLongLat && (outstanding == CNT_WIDTH'(MAX_OUTSTANDING));
    flush   = branchOrJump;
    stall   = idValid && !flush && (haz.raw || haz.waw || haz.str);
    issue   = idValid && !flush && !stall;
    incr    = issue && idLongLat;
    decr    = wbValid && (outstanding != '0);
    setEn   = incr && idRegWrite && (idRd != '0);
    clrEn   = wbValid && (wbRd != '0);
  end

  hdu_busy_table #(
    .ADDR_WIDTH(RF_ADDR_WIDTH)
  ) u_busyTable (
    .clk    (clk),
    .rst    (rst),
    .setEn  (setEn),
    .setIdx (idRd),
    .clrEn  (clrEn),
    .clrIdx (wbRd),
    .busy   (busyVec)
  );

  // In-flight counter and sticky error for a completion with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      protoErr    <= 1'b0;
    end else begin
      if (incr && !decr) begin
        outstanding <= outstanding + CNT_WIDTH'(1);
      end else if (decr && !incr) begin
        outstanding <= outstanding - CNT_WIDTH'(1);
      end
      if (wbValid && (outstanding == '0)) begin
        protoErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// tb/tb_hdu_scoreboard.sv - scoreboard-checked random and directed bench for hdu_scoreboard
module tb_hdu_scoreboard;
  import hdu_scoreboard_pkg::*;

  localparam int AW   = 5;
  localparam int MAXO = 4;
  localparam int NREG = 32;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            idValid, idUsesRs1, idUsesRs2, idRegWrite, idLongLat;
  logic [AW-1:0]   idRs1, idRs2, idRd, wbRd;
  logic            branchOrJump, wbValid;
  logic            stall, flush, issue, protoErr;
  logic [NREG-1:0] busyVec;
  logic [CW-1:0]   outstanding;

  hdu_scoreboard #(
    .RF_ADDR_WIDTH   (AW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .idValid      (idValid),
    .idRs1        (idRs1),
    .idRs2        (idRs2),
    .idUsesRs1    (idUsesRs1),
    .idUsesRs2    (idUsesRs2),
    .idRd         (idRd),
    .idRegWrite   (idRegWrite),
    .idLongLat    (idLongLat),
    .branchOrJump (branchOrJump),
    .wbValid      (wbValid),
    .wbRd         (wbRd),
    .stall        (stall),
    .flush        (flush),
    .issue        (issue),
    .busyVec      (busyVec),
    .outstanding  (outstanding),
    .protoErr     (protoErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic            stall;
    logic            flush;
    logic            issue;
    logic [NREG-1:0] busy;
    int              outst;
    logic            perr;
  } exp_t;

  exp_t expQ[$];
  int   pend[$];     // destinations of ops in flight (0 = no architectural dest)
  logic perrM = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  function automatic bit inFlight(input int r);
    foreach (pend[i]) if (pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int c, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, want);
    end
  endtask

  // One ID/WB cycle: drive inputs, predict from the reference model, then advance the model
  task automatic step(input logic r, input logic v, input int a1, input logic u1,
                      input int a2, input logic u2, input int d, input logic rw,
                      input logic ll, input logic bj, input logic wv, input int wr);
    exp_t e;
    bit raw, waw, str, st, is;
    int idx;
    @(posedge clk);
    #1;
    rst = r; idValid = v; idRs1 = AW'(a1); idUsesRs1 = u1; idRs2 = AW'(a2); idUsesRs2 = u2;
    idRd = AW'(d); idRegWrite = rw; idLongLat = ll; branchOrJump = bj; wbValid = wv; wbRd = AW'(wr);
    raw = (u1 && a1 != 0 && inFlight(a1) && !(wv && wr == a1)) ||
          (u2 && a2 != 0 && inFlight(a2) && !(wv && wr == a2));
    waw = rw && d != 0 && inFlight(d) && !(wv && wr == d);
    str = ll && (pend.size() == MAXO);
    st  = v && !bj && (raw || waw || str);
    is  = v && !bj && !st;
    e.cyc = cyc; e.stall = st; e.flush = bj; e.issue = is;
    e.busy = '0;
    foreach (pend[i]) if (pend[i] != 0) e.busy[pend[i]] = 1'b1;
    e.outst = pend.size();
    e.perr = perrM;
    expQ.push_back(e);
    cyc++;
    if (r) begin
      pend.delete();
      perrM = 1'b0;
    end else begin
      if (wv) begin
        if (pend.size() == 0) begin
          perrM = 1'b1;
        end else begin
          idx = 0;
          foreach (pend[i]) if (pend[i] == wr) idx = i;
          pend.delete(idx);
        end
      end
      if (is && ll) pend.push_back((rw && d != 0) ? d : 0);
    end
  endtask

  task automatic idle(input logic wv, input int wr);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wv, wr);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("stall", e.cyc, 64'(stall), 64'(e.stall));
      chk("flush", e.cyc, 64'(flush), 64'(e.flush));
      chk("issue", e.cyc, 64'(issue), 64'(e.issue));
      chk("busyVec", e.cyc, 64'(busyVec), 64'(e.busy));
      chk("outstanding", e.cyc, 64'(outstanding), 64'(e.outst));
      chk("protoErr", e.cyc, 64'(protoErr), 64'(e.perr));
    end
  end

  initial begin
    int a1, a2, d, wr;
    logic wv;
    rst = 1'b1; idValid = 0; idRs1 = '0; idRs2 = '0; idUsesRs1 = 0; idUsesRs2 = 0;
    idRd = '0; idRegWrite = 0; idLongLat = 0; branchOrJump = 0; wbValid = 0; wbRd = '0;
    repeat (2) @(posedge clk);

    // Load-use on x5 with completion releasing the reader
    step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 5);
    idle(0, 0);
    // Load to x0, then a reader of x0, then its completion
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 10, 1, 0, 0, 0, 0);
    idle(1, 0);
    // Fill to the limit; fifth load stalls despite a same-cycle retire
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 0, 0, 0, i, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
    idle(1, 2); idle(1, 3); idle(1, 4); idle(1, 8);
    // WAW on x7, new write issuing in the completion cycle keeps x7 busy
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7);
    idle(0, 0);
    idle(1, 7);
    // Flush overrides a RAW stall and leaves the table alone
    step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
    step(0, 1, 9, 1, 0, 0, 11, 1, 0, 1, 0, 0);
    idle(0, 0);
    idle(1, 9);
    // Completion with nothing outstanding, then reset mid-stream
    idle(1, 3);
    idle(0, 0);
    step(0, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0);
    step(1, 1, 12, 1, 0, 0, 13, 1, 1, 0, 0, 0);
    idle(0, 0);

    // Randomized traffic biased toward in-flight registers
    for (int n = 0; n < 3000; n++) begin
      a1 = (pend.size() > 0 && $urandom_range(0, 1) == 1) ? pend[$urandom_range(0, pend.size() - 1)] : int'($urandom_range(0, 31));
      a2 = (pend.size() > 0 && $urandom_range(0, 2) == 0) ? pend[$urandom_range(0, pend.size() - 1)] : int'($urandom_range(0, 31));
      d  = (pend.size() > 0 && $urandom_range(0, 3) == 0) ? pend[$urandom_range(0, pend.size() - 1)] : int'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) d = 0;
      wv = 1'b0;
      wr = 0;
      if (pend.size() > 0 && $urandom_range(0, 99) < 30) begin
        wv = 1'b1;
        wr = pend[$urandom_range(0, pend.size() - 1)];
      end else if (pend.size() == 0 && $urandom_range(0, 99) < 3) begin
        wv = 1'b1;
        wr = $urandom_range(0, 31);
      end
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 99) < 85),
           a1, 1'($urandom_range(0, 1)), a2, 1'($urandom_range(0, 1)),
           d, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 9) == 0), wv, wr);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queueDrained", cyc, 64'(expQ.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
